// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types plus inverse key schedule constants
package aes_pkg;
  typedef logic [7:0] ByteType;
  typedef logic [31:0] aes_word;
  typedef aes_word [0:3] key_128;
  localparam int NR = 10;
  localparam ByteType RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef enum logic {IDLE, EMIT} inv_kg_state_t;
  // Round r undoes expansion step r-1; rounds outside 1..NR never step back
  function automatic ByteType rcon_for(input logic [3:0] r);
    return (r == 4'd0 || r > 4'(NR)) ? 8'h00 : RCON[r - 4'd1];
  endfunction
endpackage

// File: rtl/aes_inv_key_step.sv
// aes_inv_key_step: one combinational step back through the AES-128 key schedule
module aes_inv_key_step
  import aes_pkg::*;
(
  input  key_128  key_i,
  input  ByteType rcon_i,
  input  aes_word sub_i,
  output aes_word rot_o,
  output key_128  prev_key_o
);
  aes_word w3;
  assign w3 = key_i[3] ^ key_i[2];
  assign rot_o = {w3[23:0], w3[31:24]};
  assign prev_key_o = {key_i[0] ^ sub_i ^ {rcon_i, 24'h0},
                       key_i[1] ^ key_i[0],
                       key_i[2] ^ key_i[1],
                       w3};
endmodule

// File: rtl/aes_inv_key_gen.sv
// aes_inv_key_gen: emits AES-128 round keys 10 down to 0 from the round-10 key
module aes_inv_key_gen
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  key_128      key_i,
  output aes_word     Sub_o,
  input  aes_word     Sub_i,
  output key_128      key_o,
  output logic [3:0]  round_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);
  inv_kg_state_t state_q, state_d;
  key_128        key_q, key_d, prev_key;
  logic [3:0]    round_q, round_d;
  logic          done_q, done_d;
  logic          hs;
  aes_inv_key_step u_step (
    .key_i     (key_q),
    .rcon_i    (rcon_for(round_q)),
    .sub_i     (Sub_i),
    .rot_o     (Sub_o),
    .prev_key_o(prev_key)
  );
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end
  assign hs = (state_q == EMIT) && ready_i;
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = EMIT;
      key_d   = key_i;
      round_d = 4'(NR);
    end else if (hs && round_q == 4'd0) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else if (hs) begin
      key_d   = prev_key;
      round_d = round_q - 4'd1;
    end
  end
  always_comb begin
    valid_o = state_q == EMIT;
    busy_o  = state_q == EMIT;
    done_o  = done_q;
    key_o   = key_q;
    round_o = round_q;
  end
endmodule

// File: doc/aes_inv_key_gen.md
# aes_inv_key_gen

Inverse AES-128 key schedule for the decryption datapath. It takes the final (round-10) round key and emits round keys 10 down to 0, one per valid/ready handshake. It sits beside the forward key generator and feeds the inverse-cipher round pipeline. Like the forward generator, it uses the shared external S-box through a Sub_o/Sub_i word pair.

## Interface
Parameters:
- none (AES-128 only; round count fixed by package constant NR = 10)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- nrst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a schedule; sampled only in IDLE
- key_i  in  aes_pkg::key_128  round-10 key, captured on accepted start; key_i[0] = bits 127:96 of the FIPS hex string
- Sub_o  out  aes_pkg::aes_word  RotWord of the derived word w'[3], i.e. {w'[3][23:0], w'[3][31:24]}, sent to the external S-box
- Sub_i  in  aes_pkg::aes_word  SubWord(Sub_o), returned combinationally in the same cycle
- key_o  out  aes_pkg::key_128  current round key, registered
- round_o  out  4  round index of key_o (10..0)
- valid_o  out  1  key_o/round_o valid
- ready_i  in  1  consumer accepts key_o when valid_o && ready_i
- busy_o  out  1  high in EMIT state
- done_o  out  1  one-cycle pulse after round-0 key is accepted

## Operation
- States: IDLE, EMIT.
- IDLE, start = 1: latch key_i into the key register, set round register to 10, go to EMIT. start is ignored in every other state.
- EMIT: valid_o = 1.
  - Handshake with round_o > 0: key register gets prev_key, round register decrements.
  - Handshake with round_o == 0: go to IDLE, pulse done_o.
  - No handshake (ready_i = 0): key register, round register and all outputs hold steady.
- prev_key, from current words w[0..3] with r = round_o:
  - w'[3] = w[3]^w[2]
  - w'[2] = w[2]^w[1]
  - w'[1] = w[1]^w[0]
  - w'[0] = w[0] ^ Sub_i ^ {RCON[r-1], 24'h0}
- RCON[0..9] = 01,02,04,08,10,20,40,80,1B,36. The RCON index is r-1 only; index 10 and negative indices are never used.
- Sub_o is driven continuously from the key register. Its value is don't-care outside EMIT and must not affect state there.
- Reset (asynchronous, valid at any time including mid-schedule):
  - state = IDLE
  - key_o = 0, round_o = 0
  - valid_o = 0, busy_o = 0, done_o = 0
  - No partial schedule survives reset.
- A start arriving in the cycle of the final handshake is ignored, because the block is still in EMIT.

## Timing
- start accepted at edge t: valid_o = 1, key_o = key_i, round_o = 10 from t+1.
- With ready_i held high: one key per cycle. Round k appears at t+1+(10-k), so round 0 appears at t+11.
- done_o is high for the one cycle after the round-0 handshake edge; busy_o and valid_o are low in that same cycle.
- Earliest next start is accepted in the cycle done_o is high.
- Combinational path: key register -> Sub_o -> external S-box -> Sub_i -> prev_key -> key register. This is a single-cycle path and is budgeted at the system level.

## Structure
- aes_pkg gains:
  - RCON table constant (ByteType[10])
  - NR = 10
  - enum inv_kg_state_t {IDLE, EMIT}
  - reuses existing key_128 and aes_word
- Sub-module aes_inv_key_step: purely combinational.
  - Inputs: key_128 and rcon byte.
  - Outputs: rot word for the S-box and prev_key (given Sub_i).
  - Reusable by a future unrolled variant.
- Top level holds the FSM, round counter, key register and handshake logic.

## Test plan
- FIPS-197 A.1 vector: start with key_i = d014f9a8c9ee2589e13f0cc8b6630ca6, ready_i = 1.
  - Expect round 10 = same value at t+1.
  - Expect round 9 = ac7766f319fadc2128d12941575c006e.
  - Expect round 1 = a0fafe1788542cb123a339392a6c7605.
  - Expect round 0 = 2b7e151628aed2a6abf7158809cf4f3c at t+11.
  - Expect done_o pulse at t+12.
- Backpressure: same vector with ready_i toggled pseudo-randomly.
  - Expect an identical 11-key sequence.
  - key_o and round_o stable while valid_o && !ready_i.
  - done_o exactly once.
- start while busy: pulse start with a different key_i at round 5.
  - Expect the sequence unaffected.
  - Pulse start in the round-0 handshake cycle: expect it ignored and state IDLE after.
- Reset mid-operation: assert nrst = 0 asynchronously between edges at round 4.
  - Expect immediately valid_o = 0, busy_o = 0, key_o = 0, round_o = 0.
  - After release, a new start yields a correct full sequence.
- Round trip: run the forward key generator on a random cipher key and feed its round-10 output here.
  - Expect every emitted round key to match the forward schedule in reverse order.
  - Repeat for 100 random keys.
